// File: rtl/cnt_iter_ctrl_if.sv
// Handshake and operand/result bundle for the iterative count sequencer.
interface cnt_iter_ctrl_if #(
    parameter int unsigned WIDTH = 64
);
    logic             StartE;
    logic             FlushE;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] RevA;
    logic [1:0]       B;
    logic             W64;
    logic             Ready;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] CntResult;

    modport master (
        output StartE, FlushE, A, RevA, B, W64,
        input  Ready, Busy, Done, CntResult
    );

    modport slave (
        input  StartE, FlushE, A, RevA, B, W64,
        output Ready, Busy, Done, CntResult
    );
endinterface

// File: rtl/cnt_iter_ctrl.sv
// Iterative clz/ctz/cpop sequencer: scans the MSB-aligned operand CHUNK bits
// per cycle through one lzc/popcount slice and accumulates the count.
module cnt_iter_ctrl #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CHUNK = 8
) (
    input  logic            clk,
    input  logic            reset,
    cnt_iter_ctrl_if.slave  bus
);
    localparam int unsigned AW    = $clog2(WIDTH) + 1;
    localparam int unsigned NCH   = WIDTH / CHUNK;
    localparam int unsigned NCH_W = 32 / CHUNK;
    localparam int unsigned CW    = $clog2(NCH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] sh_q;
    logic [AW-1:0]    acc_q;
    logic [CW-1:0]    cnt_q;
    logic             cpop_q;
    logic [WIDTH-1:0] res_q;

    logic [CHUNK-1:0] chunk;
    logic             chunk_nz;
    logic [AW-1:0]    acc_d;
    logic             last_d;
    logic [WIDTH-1:0] sh_d;
    logic [CW-1:0]    cnt_d;
    logic [WIDTH-1:0] a_word;
    logic [WIDTH-1:0] reva_word;
    logic             word;

    function automatic logic [AW-1:0] lzc(input logic [CHUNK-1:0] c);
        logic [AW-1:0] n;
        logic          hit;
        n   = '0;
        hit = 1'b0;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            if (c[CHUNK-1-i]) hit = 1'b1;
            else if (!hit)    n = n + 1'b1;
        end
        return n;
    endfunction

    function automatic logic [AW-1:0] popcnt(input logic [CHUNK-1:0] c);
        logic [AW-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < CHUNK; i++) n = n + AW'(c[i]);
        return n;
    endfunction

    // Word ops put the 32 significant bits at the top so the scan order is unchanged.
    generate
        if (WIDTH > 32) begin : g_word
            assign a_word    = {bus.A[31:0], {(WIDTH-32){1'b0}}};
            assign reva_word = {bus.RevA[WIDTH-1 -: 32], {(WIDTH-32){1'b0}}};
            assign word      = bus.W64;
        end else begin : g_noword
            assign a_word    = bus.A;
            assign reva_word = bus.RevA;
            assign word      = 1'b0;
        end
    endgenerate

    always_comb begin
        chunk    = sh_q[WIDTH-1 -: CHUNK];
        chunk_nz = |chunk;
        if (cpop_q)        acc_d = acc_q + popcnt(chunk);
        else if (chunk_nz) acc_d = acc_q + lzc(chunk);
        else               acc_d = acc_q + AW'(CHUNK);
        last_d = (cnt_q == '0) || (!cpop_q && chunk_nz);

        if (bus.B == 2'b01) sh_d = word ? reva_word : bus.RevA;
        else                sh_d = word ? a_word    : bus.A;
        cnt_d = word ? CW'(NCH_W - 1) : CW'(NCH - 1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            cpop_q  <= 1'b0;
            res_q   <= '0;
        end else if (bus.FlushE) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.StartE) begin
                        state_q <= S_RUN;
                        sh_q    <= sh_d;
                        acc_q   <= '0;
                        cnt_q   <= cnt_d;
                        cpop_q  <= bus.B[1];
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    acc_q <= acc_d;
                    sh_q  <= sh_q << CHUNK;
                    cnt_q <= cnt_q - 1'b1;
                    if (last_d) begin
                        state_q <= S_DONE;
                        res_q   <= WIDTH'(acc_d);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.Ready     = (state_q != S_RUN);
    assign bus.Busy      = (state_q == S_RUN);
    assign bus.Done      = (state_q == S_DONE);
    assign bus.CntResult = res_q;
endmodule

// File: tb/tb_cnt_iter_ctrl.sv
// Randomised self-checking bench for cnt_iter_ctrl (64/8 and 32/4 instances)
// against an arithmetic count/latency reference model.
module tb_cnt_iter_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    cnt_iter_ctrl_if #(.WIDTH(64)) bus64();
    cnt_iter_ctrl_if #(.WIDTH(32)) bus32();

    cnt_iter_ctrl #(.WIDTH(64), .CHUNK(8)) dut64 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus64.slave)
    );

    cnt_iter_ctrl #(.WIDTH(32), .CHUNK(4)) dut32 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus32.slave)
    );

    function automatic logic [63:0] rev64(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[i] = x[63-i];
        return r;
    endfunction

    // Reference: counts on the L low bits of A; latency from first nonzero chunk.
    task automatic model(input logic [63:0] a, input logic [1:0] b, input bit w64,
                         input int w, input int c, output int res, output int n);
        int L;
        L   = (w == 64 && w64) ? 32 : w;
        res = 0;
        if (b[1]) begin
            for (int i = 0; i < L; i++) res += int'(a[i]);
            n = L / c;
        end else begin
            if (b == 2'b00) begin
                for (int i = L - 1; i >= 0; i--) begin
                    if (a[i]) break;
                    res++;
                end
            end else begin
                for (int i = 0; i < L; i++) begin
                    if (a[i]) break;
                    res++;
                end
            end
            n = (res == L) ? L / c : res / c + 1;
        end
    endtask

    task automatic set_ops(input bit w32, input logic [63:0] a, input logic [1:0] b, input bit w64);
        logic [63:0] r;
        r = rev64(a);
        if (w32) begin
            bus32.A = a[31:0]; bus32.RevA = r[63:32]; bus32.B = b; bus32.W64 = w64;
        end else begin
            bus64.A = a; bus64.RevA = r; bus64.B = b; bus64.W64 = w64;
        end
    endtask

    task automatic set_ctl(input bit w32, input bit start, input bit flush);
        if (w32) begin bus32.StartE = start; bus32.FlushE = flush; end
        else     begin bus64.StartE = start; bus64.FlushE = flush; end
    endtask

    function automatic logic get_busy(input bit w32);
        return w32 ? bus32.Busy : bus64.Busy;
    endfunction
    function automatic logic get_done(input bit w32);
        return w32 ? bus32.Done : bus64.Done;
    endfunction
    function automatic logic get_ready(input bit w32);
        return w32 ? bus32.Ready : bus64.Ready;
    endfunction
    function automatic logic [63:0] get_res(input bit w32);
        return w32 ? {32'b0, bus32.CntResult} : bus64.CntResult;
    endfunction

    task automatic run_op(input bit w32, input logic [63:0] a, input logic [1:0] b, input bit w64,
                          input int exp_res, input int exp_n, input string name);
        int          cycles;
        int          guard;
        logic [63:0] res;
        @(negedge clk);
        set_ops(w32, a, b, w64);
        set_ctl(w32, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        set_ctl(w32, 1'b0, 1'b0);
        set_ops(w32, ~a, ~b, ~w64);
        cycles = 0;
        guard  = 0;
        while (get_done(w32) !== 1'b1 && guard < 300) begin
            if (get_busy(w32) === 1'b1) cycles++;
            guard++;
            @(negedge clk);
        end
        checks++;
        if (get_done(w32) !== 1'b1) begin
            failures++;
            $display("FAIL %s done_timeout got Done=%b want 1 within 300 cycles", name, get_done(w32));
        end else begin
            checks++;
            if (cycles !== exp_n) begin
                failures++;
                $display("FAIL %s run_cycles got %0d want %0d", name, cycles, exp_n);
            end
            res = get_res(w32);
            checks++;
            if (res !== 64'(exp_res)) begin
                failures++;
                $display("FAIL %s result got %0d want %0d", name, res, exp_res);
            end
            checks++;
            if (get_ready(w32) !== 1'b1) begin
                failures++;
                $display("FAIL %s ready_in_done got %b want 1", name, get_ready(w32));
            end
        end
        @(negedge clk);
        checks++;
        if (get_done(w32) !== 1'b0 || get_busy(w32) !== 1'b0) begin
            failures++;
            $display("FAIL %s after_done got Done=%b Busy=%b want 0 0", name, get_done(w32), get_busy(w32));
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_ctl(1'b0, 1'b0, 1'b0);
        set_ctl(1'b1, 1'b0, 1'b0);
        set_ops(1'b0, 64'd0, 2'b00, 1'b0);
        set_ops(1'b1, 64'd0, 2'b00, 1'b0);
        #2;
        checks++;
        if (bus64.Ready !== 1'b1 || bus64.Busy !== 1'b0 || bus64.Done !== 1'b0 || bus64.CntResult !== 64'd0) begin
            failures++;
            $display("FAIL reset64 got R=%b B=%b D=%b res=%0h want 1 0 0 0",
                     bus64.Ready, bus64.Busy, bus64.Done, bus64.CntResult);
        end
        checks++;
        if (bus32.Ready !== 1'b1 || bus32.Busy !== 1'b0 || bus32.Done !== 1'b0 || bus32.CntResult !== 32'd0) begin
            failures++;
            $display("FAIL reset32 got R=%b B=%b D=%b res=%0h want 1 0 0 0",
                     bus32.Ready, bus32.Busy, bus32.Done, bus32.CntResult);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_directed();
        run_op(1'b0, 64'h0000_0000_0001_0000, 2'b00, 1'b0, 47, 6, "clz_47");
        run_op(1'b0, '1,                      2'b10, 1'b0, 64, 8, "cpop_ones");
        run_op(1'b0, 64'hFFFF_FFFF_0000_000F, 2'b11, 1'b1, 4,  4, "cpop_word");
        run_op(1'b0, 64'd0,                   2'b01, 1'b1, 32, 4, "ctz_word_zero");
        run_op(1'b0, 64'd0,                   2'b00, 1'b0, 64, 8, "clz_zero");
        run_op(1'b0, 64'h0000_0000_0000_0010, 2'b01, 1'b0, 4,  1, "ctz_4");
        run_op(1'b1, 64'h0000_0000_8000_0000, 2'b00, 1'b1, 0,  1, "w32_clz_msb");
        run_op(1'b1, 64'd0,                   2'b01, 1'b0, 32, 8, "w32_ctz_zero");
    endtask

    task automatic test_random();
        logic [63:0] a;
        logic [1:0]  b;
        bit          w64;
        bit          w32;
        int          r;
        int          n;
        for (int i = 0; i < 60; i++) begin
            w32 = (i % 4 == 3);
            a   = {$urandom(), $urandom()};
            case ($urandom_range(0, 4))
                0: a = a >> $urandom_range(0, 63);
                1: a = a << $urandom_range(0, 63);
                2: a = '0;
                3: a = 64'd1 << $urandom_range(0, 63);
                default: ;
            endcase
            b   = 2'($urandom_range(0, 3));
            w64 = 1'($urandom_range(0, 1));
            model(a, b, w64, w32 ? 32 : 64, w32 ? 4 : 8, r, n);
            run_op(w32, a, b, w64, r, n, w32 ? "rand32" : "rand64");
        end
    endtask

    task automatic test_flush();
        bit seen_done;
        run_op(1'b0, 64'h0000_0000_0001_0000, 2'b00, 1'b0, 47, 6, "pre_flush");
        @(negedge clk);
        set_ops(1'b0, 64'd0, 2'b00, 1'b0);
        set_ctl(1'b0, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        set_ctl(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus64.Busy !== 1'b1) begin
            failures++;
            $display("FAIL flush_busy_run3 got %b want 1", bus64.Busy);
        end
        set_ctl(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        set_ctl(1'b0, 1'b0, 1'b0);
        checks++;
        if (bus64.Busy !== 1'b0 || bus64.Ready !== 1'b1 || bus64.Done !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle got B=%b R=%b D=%b want 0 1 0", bus64.Busy, bus64.Ready, bus64.Done);
        end
        seen_done = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus64.Done === 1'b1 || bus64.Busy === 1'b1) seen_done = 1'b1;
        end
        checks++;
        if (seen_done) begin
            failures++;
            $display("FAIL flush_no_done got activity=1 want 0");
        end
        checks++;
        if (bus64.CntResult !== 64'd47) begin
            failures++;
            $display("FAIL flush_result_kept got %0d want 47", bus64.CntResult);
        end
        set_ctl(1'b0, 1'b1, 1'b1);
        @(negedge clk);
        set_ctl(1'b0, 1'b0, 1'b0);
        checks++;
        if (bus64.Busy !== 1'b0 || bus64.Ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_beats_start got B=%b R=%b want 0 1", bus64.Busy, bus64.Ready);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [63:0] a [3];
        logic [1:0]  b [3];
        int          er [3];
        int          en [3];
        int          cycles;
        int          guard;
        for (int i = 0; i < 3; i++) begin
            a[i] = {$urandom(), $urandom()} >> $urandom_range(0, 40);
            b[i] = 2'(i);
            model(a[i], b[i], 1'b0, 64, 8, er[i], en[i]);
        end
        @(negedge clk);
        set_ops(1'b0, a[0], b[0], 1'b0);
        set_ctl(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (bus64.Busy !== 1'b1) begin
                failures++;
                $display("FAIL b2b_busy op%0d got %b want 1", i, bus64.Busy);
            end
            if (i < 2) set_ops(1'b0, a[i+1], b[i+1], 1'b0);
            else       set_ctl(1'b0, 1'b0, 1'b0);
            cycles = 0;
            guard  = 0;
            while (bus64.Done !== 1'b1 && guard < 300) begin
                if (bus64.Busy === 1'b1) cycles++;
                guard++;
                @(negedge clk);
            end
            checks++;
            if (bus64.Done !== 1'b1 || cycles !== en[i]) begin
                failures++;
                $display("FAIL b2b_cycles op%0d got %0d (Done=%b) want %0d", i, cycles, bus64.Done, en[i]);
            end
            checks++;
            if (bus64.CntResult !== 64'(er[i])) begin
                failures++;
                $display("FAIL b2b_result op%0d got %0d want %0d", i, bus64.CntResult, er[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (bus64.Done !== 1'b0 || bus64.Busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end got D=%b B=%b want 0 0", bus64.Done, bus64.Busy);
        end
    endtask

    task automatic test_reset_mid_run();
        bit activity;
        @(negedge clk);
        set_ops(1'b0, 64'd0, 2'b00, 1'b0);
        set_ctl(1'b0, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        set_ctl(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus64.Busy !== 1'b0 || bus64.Done !== 1'b0 || bus64.Ready !== 1'b1 || bus64.CntResult !== 64'd0) begin
            failures++;
            $display("FAIL reset_mid_run got B=%b D=%b R=%b res=%0d want 0 0 1 0",
                     bus64.Busy, bus64.Done, bus64.Ready, bus64.CntResult);
        end
        @(negedge clk);
        reset = 1'b0;
        activity = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus64.Done === 1'b1 || bus64.Busy === 1'b1) activity = 1'b1;
        end
        checks++;
        if (activity) begin
            failures++;
            $display("FAIL reset_no_done got activity=1 want 0");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_back_to_back();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
